// File: rtl/vit_cls_head_if.sv
// Control and data bundle for the ViT classification head.
// The master drives start, tokens, weights and biases; the slave returns logits and argmax.
interface vit_cls_head_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int SEQ_LEN     = 16,
  parameter int EMB_DIM     = 16,
  parameter int NUM_CLASSES = 10
);
  localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  logic                         start;
  logic signed [DATA_WIDTH-1:0] x_in   [SEQ_LEN*EMB_DIM];
  logic signed [DATA_WIDTH-1:0] W_head [EMB_DIM*NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0] b_head [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0] logits [NUM_CLASSES];
  logic        [CLS_W-1:0]      class_idx;
  logic                         done;
  logic                         out_valid;

  modport master (
    output start, x_in, W_head, b_head,
    input  logits, class_idx, done, out_valid
  );

  modport slave (
    input  start, x_in, W_head, b_head,
    output logits, class_idx, done, out_valid
  );
endinterface

// File: rtl/vit_cls_head.sv
// ViT classification head: pool (CLS token or mean), linear projection + bias through one
// shared MAC, then a sequential argmax. SEQ_LEN must be a power of two, at least 2.
module vit_cls_head #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int SEQ_LEN     = 16,
  parameter int EMB_DIM     = 16,
  parameter int NUM_CLASSES = 10,
  parameter int POOL_MODE   = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  vit_cls_head_if.slave bus
);
  localparam int TW = $clog2(SEQ_LEN);
  localparam int EW = (EMB_DIM > 1) ? $clog2(EMB_DIM) : 1;
  localparam int CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int XW = $clog2(SEQ_LEN*EMB_DIM);
  localparam int WW = (EMB_DIM*NUM_CLASSES > 1) ? $clog2(EMB_DIM*NUM_CLASSES) : 1;
  localparam int SW = DATA_WIDTH + TW;
  localparam int AW = 2*DATA_WIDTH + $clog2(EMB_DIM) + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_POOL   = 3'd1;
  localparam logic [2:0] S_MAC    = 3'd2;
  localparam logic [2:0] S_ARGMAX = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]                   state_reg;
  logic [TW-1:0]                t_cnt_reg;
  logic [EW-1:0]                e_cnt_reg;
  logic [CW-1:0]                c_cnt_reg;
  logic signed [SW-1:0]         sum_reg;
  logic signed [AW-1:0]         acc_reg;
  logic signed [DATA_WIDTH-1:0] pooled_reg      [EMB_DIM];
  logic signed [DATA_WIDTH-1:0] logits_next_reg [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0] logits_reg      [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0] max_reg;
  logic [CW-1:0]                idx_reg;
  logic [CW-1:0]                class_idx_reg;
  logic                         done_reg;

  logic                         t_last, e_last, c_last;
  logic [XW-1:0]                x_idx;
  logic [WW-1:0]                w_idx;
  logic signed [DATA_WIDTH-1:0] x_sel, w_sel, b_sel, p_sel, cand;
  logic signed [SW-1:0]         x_ext, sum_next;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [AW-1:0]         prod_ext, bias_ext, acc_next;
  logic                         take;
  logic [CW-1:0]                idx_final;

  assign t_last = (t_cnt_reg == TW'(SEQ_LEN-1));
  assign e_last = (e_cnt_reg == EW'(EMB_DIM-1));
  assign c_last = (c_cnt_reg == CW'(NUM_CLASSES-1));

  assign x_idx = XW'(t_cnt_reg) * XW'(EMB_DIM) + XW'(e_cnt_reg);
  assign w_idx = WW'(e_cnt_reg) * WW'(NUM_CLASSES) + WW'(c_cnt_reg);

  assign x_sel = bus.x_in[x_idx];
  assign w_sel = bus.W_head[w_idx];
  assign b_sel = bus.b_head[c_cnt_reg];
  assign p_sel = pooled_reg[e_cnt_reg];

  // Mean pooling: the floor shift is just dropping the low log2(SEQ_LEN) bits.
  assign x_ext    = {{TW{x_sel[DATA_WIDTH-1]}}, x_sel};
  assign sum_next = (t_cnt_reg == '0) ? x_ext : sum_reg + x_ext;

  assign prod     = p_sel * w_sel;
  assign prod_ext = {{(AW-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
  assign bias_ext = $signed({{(AW-DATA_WIDTH){b_sel[DATA_WIDTH-1]}}, b_sel}) <<< FRAC_BITS;
  assign acc_next = ((e_cnt_reg == '0) ? bias_ext : acc_reg) + prod_ext;

  assign cand      = logits_next_reg[c_cnt_reg];
  assign take      = (c_cnt_reg == '0) || (cand > max_reg);
  assign idx_final = take ? c_cnt_reg : idx_reg;

  function automatic logic signed [DATA_WIDTH-1:0] sat_fn(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] s;
    s = v >>> FRAC_BITS;
    if ((&s[AW-1:DATA_WIDTH-1]) || !(|s[AW-1:DATA_WIDTH-1]))
      return s[DATA_WIDTH-1:0];
    else if (s[AW-1])
      return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      t_cnt_reg     <= '0;
      e_cnt_reg     <= '0;
      c_cnt_reg     <= '0;
      sum_reg       <= '0;
      acc_reg       <= '0;
      max_reg       <= '0;
      idx_reg       <= '0;
      class_idx_reg <= '0;
      done_reg      <= 1'b0;
      for (int i = 0; i < EMB_DIM; i++) pooled_reg[i] <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        logits_next_reg[i] <= '0;
        logits_reg[i]      <= '0;
      end
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            state_reg <= S_POOL;
            t_cnt_reg <= '0;
            e_cnt_reg <= '0;
            c_cnt_reg <= '0;
          end
        end
        S_POOL: begin
          if (POOL_MODE == 0) begin
            for (int i = 0; i < EMB_DIM; i++) pooled_reg[i] <= bus.x_in[i];
            state_reg <= S_MAC;
          end else begin
            sum_reg <= sum_next;
            if (t_last) begin
              pooled_reg[e_cnt_reg] <= DATA_WIDTH'(sum_next >>> TW);
              t_cnt_reg <= '0;
              if (e_last) begin
                e_cnt_reg <= '0;
                state_reg <= S_MAC;
              end else begin
                e_cnt_reg <= e_cnt_reg + EW'(1);
              end
            end else begin
              t_cnt_reg <= t_cnt_reg + TW'(1);
            end
          end
        end
        S_MAC: begin
          acc_reg <= acc_next;
          if (e_last) begin
            logits_next_reg[c_cnt_reg] <= sat_fn(acc_next);
            e_cnt_reg <= '0;
            if (c_last) begin
              c_cnt_reg <= '0;
              state_reg <= S_ARGMAX;
            end else begin
              c_cnt_reg <= c_cnt_reg + CW'(1);
            end
          end else begin
            e_cnt_reg <= e_cnt_reg + EW'(1);
          end
        end
        S_ARGMAX: begin
          if (take) begin
            max_reg <= cand;
            idx_reg <= c_cnt_reg;
          end
          // Results are published on the edge into S_DONE so they are visible with done.
          if (c_last) begin
            for (int i = 0; i < NUM_CLASSES; i++) logits_reg[i] <= logits_next_reg[i];
            class_idx_reg <= idx_final;
            done_reg      <= 1'b1;
            c_cnt_reg     <= '0;
            state_reg     <= S_DONE;
          end else begin
            c_cnt_reg <= c_cnt_reg + CW'(1);
          end
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_out
    assign bus.logits[gi] = logits_reg[gi];
  end
  assign bus.class_idx = class_idx_reg;
  assign bus.done      = done_reg;
  assign bus.out_valid = done_reg;
endmodule

// File: tb/tb_vit_cls_head.sv
// Bench for vit_cls_head: one CLS-mode and one mean-mode instance checked against
// an arithmetic reference model, plus literal expectations from hand calculation.
module tb_vit_cls_head;
  localparam int DW = 16, FB = 8, SL = 16, ED = 16, NC = 10;
  localparam int LAT0 = 1 + 1 + ED*NC + NC;
  localparam int LAT1 = 1 + SL*ED + ED*NC + NC;

  typedef logic signed [DW-1:0] lvec_t [NC];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [DW-1:0] xs [SL*ED];
  logic signed [DW-1:0] ws [ED*NC];
  logic signed [DW-1:0] bs [NC];

  vit_cls_head_if #(.DATA_WIDTH(DW), .SEQ_LEN(SL), .EMB_DIM(ED), .NUM_CLASSES(NC)) bus0 ();
  vit_cls_head_if #(.DATA_WIDTH(DW), .SEQ_LEN(SL), .EMB_DIM(ED), .NUM_CLASSES(NC)) bus1 ();

  assign bus0.x_in = xs;  assign bus0.W_head = ws;  assign bus0.b_head = bs;
  assign bus1.x_in = xs;  assign bus1.W_head = ws;  assign bus1.b_head = bs;

  vit_cls_head #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .SEQ_LEN(SL), .EMB_DIM(ED),
                 .NUM_CLASSES(NC), .POOL_MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  vit_cls_head #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .SEQ_LEN(SL), .EMB_DIM(ED),
                 .NUM_CLASSES(NC), .POOL_MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int checks = 0, errors = 0;
  int exp_logits [2][NC];
  int exp_cls [2];
  int start_cyc [2];
  bit armed [2];
  int done_cnt [2];

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic longint floor_div(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: pool, project with exact integer arithmetic, floor to Q8.8, clamp, argmax.
  task automatic run_model(input int k);
    longint p [ED];
    longint s, a;
    int best;
    for (int e = 0; e < ED; e++) begin
      if (k == 0) p[e] = xs[e];
      else begin
        s = 0;
        for (int t = 0; t < SL; t++) s += xs[t*ED+e];
        p[e] = floor_div(s, SL);
      end
    end
    for (int c = 0; c < NC; c++) begin
      a = longint'(bs[c]) * (64'sd1 <<< FB);
      for (int e = 0; e < ED; e++) a += p[e] * longint'(ws[e*NC+c]);
      a = floor_div(a, 64'sd1 <<< FB);
      if (a > 32767) a = 32767;
      if (a < -32768) a = -32768;
      exp_logits[k][c] = int'(a);
    end
    best = 0;
    for (int c = 1; c < NC; c++) if (exp_logits[k][c] > exp_logits[k][best]) best = c;
    exp_cls[k] = best;
  endtask

  // Single compare process for both instances.
  initial begin
    logic d, ov;
    lvec_t lg;
    logic [3:0] ci;
    int lat;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        armed[0] = 1'b0;
        armed[1] = 1'b0;
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (k == 0) begin d = bus0.done; ov = bus0.out_valid; lg = bus0.logits; ci = bus0.class_idx; end
          else        begin d = bus1.done; ov = bus1.out_valid; lg = bus1.logits; ci = bus1.class_idx; end
          lat = (k == 0) ? LAT0 : LAT1;
          if (d || ov) begin
            check($sformatf("out_valid_eq_done%0d", k), ov, d);
            if (!armed[k]) begin
              checks++; errors++;
              $display("FAIL unexpected_done%0d: got done=1 required done=0 at cycle %0d", k, cyc);
            end else begin
              check($sformatf("latency%0d", k), cyc - start_cyc[k], lat);
              for (int c = 0; c < NC; c++)
                check($sformatf("logit%0d[%0d]", k, c), lg[c], exp_logits[k][c]);
              check($sformatf("class_idx%0d", k), ci, exp_cls[k]);
              armed[k] = 1'b0;
            end
            done_cnt[k]++;
          end else if (armed[k] && (cyc - start_cyc[k] > lat)) begin
            checks++; errors++;
            $display("FAIL missing_done%0d: got no done by cycle %0d required done at %0d", k, cyc - start_cyc[k], lat);
            armed[k] = 1'b0;
          end
        end
      end
    end
  end

  // Callers are positioned 1 time unit after a rising edge.
  task automatic go(input int k);
    run_model(k);
    if (k == 0) bus0.start = 1'b1; else bus1.start = 1'b1;
    start_cyc[k] = cyc;
    armed[k] = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget);
    int n0, n;
    n0 = done_cnt[k];
    n = 0;
    while (done_cnt[k] == n0 && n < budget) begin @(posedge clk); n++; end
    check($sformatf("done_seen%0d", k), done_cnt[k] - n0, 1);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic signed [DW-1:0] tok0, input logic signed [DW-1:0] rest,
                      input logic signed [DW-1:0] w, input logic signed [DW-1:0] b);
    for (int i = 0; i < SL*ED; i++) xs[i] = (i < ED) ? tok0 : rest;
    for (int i = 0; i < ED*NC; i++) ws[i] = w;
    for (int i = 0; i < NC; i++) bs[i] = b;
  endtask

  task automatic fill_test1();
    fill(16'sh0100, 16'sh7FFF, 16'sh0000, 16'sh0000);
    for (int e = 0; e < ED; e++)
      for (int c = 0; c < NC; c++) ws[e*NC+c] = DW'(c * 16);
  endtask

  task automatic fill_mean(input bit neg);
    fill(16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000);
    for (int t = 0; t < SL; t++)
      for (int e = 0; e < ED; e++) xs[t*ED+e] = neg ? DW'(-t * 256) : DW'(t * 256);
    for (int e = 0; e < ED; e++) ws[e*NC] = 16'sh0100;
  endtask

  initial begin
    int n0;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    fill(16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000);
    idle(3);
    rst_n = 1'b1;

    check("reset_logit0_0", bus0.logits[0], 0);
    check("reset_logit0_9", bus0.logits[9], 0);
    check("reset_class0", bus0.class_idx, 0);
    check("reset_done0", bus0.done, 0);
    check("reset_logit1_5", bus1.logits[5], 0);
    check("reset_valid1", bus1.out_valid, 0);

    // CLS pooling with a linear ramp of weights
    fill_test1();
    go(0);
    check("model_t1_logit9", exp_logits[0][9], 2304);
    wait_done(0, 400);
    for (int c = 0; c < NC; c++) check($sformatf("t1_logit[%0d]", c), bus0.logits[c], c * 256);
    check("t1_class", bus0.class_idx, 9);

    // Bias-only ties resolve to the lowest index
    fill(16'sh0100, 16'sh0000, 16'sh0000, 16'sh0080);
    go(0);
    wait_done(0, 400);
    check("t2_logit0", bus0.logits[0], 128);
    check("t2_logit9", bus0.logits[9], 128);
    check("t2_class", bus0.class_idx, 0);
    bs[3] = 16'sh0200;
    bs[7] = 16'sh0200;
    go(0);
    wait_done(0, 400);
    check("t2b_logit7", bus0.logits[7], 512);
    check("t2b_class", bus0.class_idx, 3);

    // Saturation at both rails
    fill(16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh0000);
    go(0);
    wait_done(0, 400);
    check("t3_logit0", bus0.logits[0], 32767);
    check("t3_logit9", bus0.logits[9], 32767);
    fill(16'sh7FFF, 16'sh7FFF, 16'sh8000, 16'sh0000);
    go(0);
    wait_done(0, 400);
    check("t3b_logit4", bus0.logits[4], -32768);
    check("t3b_class", bus0.class_idx, 0);

    // Mean pooling, positive and negative ramps
    fill_mean(1'b0);
    go(1);
    check("model_t4_logit0", exp_logits[1][0], 30720);
    wait_done(1, 700);
    check("t4_logit0", bus1.logits[0], 30720);
    check("t4_logit1", bus1.logits[1], 0);
    check("t4_class", bus1.class_idx, 0);
    fill_mean(1'b1);
    go(1);
    wait_done(1, 700);
    check("t4b_logit0", bus1.logits[0], -30720);
    check("t4b_class", bus1.class_idx, 1);

    // Stray start during S_MAC is ignored
    fill_test1();
    n0 = done_cnt[0];
    go(0);
    idle(40);
    bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    wait_done(0, 400);
    idle(200);
    check("stray_start_done_count", done_cnt[0] - n0, 1);

    // Reset mid-S_POOL aborts without a done
    fill_mean(1'b0);
    n0 = done_cnt[1];
    go(1);
    idle(100);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_logit0", bus1.logits[0], 0);
    check("abort_class", bus1.class_idx, 0);
    check("abort_done", bus1.done, 0);
    check("abort_dut0_logit9", bus0.logits[9], 0);
    idle(500);
    check("abort_no_done", done_cnt[1] - n0, 0);
    go(1);
    wait_done(1, 700);
    check("after_abort_logit0", bus1.logits[0], 30720);

    // Back-to-back: second start lands in the idle cycle right after done
    fill_test1();
    go(0);
    wait_done(0, 400);
    fill(16'sh0100, 16'sh0000, 16'sh0000, 16'sh0080);
    bs[3] = 16'sh0200;
    bs[7] = 16'sh0200;
    go(0);
    wait_done(0, 400);
    check("b2b_class", bus0.class_idx, 3);
    check("b2b_logit3", bus0.logits[3], 512);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
